// File: rtl/instr_encoder_loader_if.sv
// Request channel of the instruction encoder/loader: a symbolic MIPS instruction
// (operation class plus raw fields) carried over a valid/ready handshake.
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_sel;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  modport master (
    output in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target,
    input  in_ready
  );

  modport slave (
    input  in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Assembles symbolic instruction requests into 32-bit MIPS words and writes them
// sequentially into the instruction-memory write port, one word per two cycles.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_encoder_loader_if.slave req,
  output logic                  imem_we,
  output logic [ADDR_W-1:0]     imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  err,
  output logic                  done,
  output logic [ADDR_W:0]       count
);

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  localparam logic [2:0] OP_R    = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd1;
  localparam logic [2:0] OP_SW   = 3'd2;
  localparam logic [2:0] OP_BEQ  = 3'd3;
  localparam logic [2:0] OP_J    = 3'd4;
  localparam logic [2:0] OP_ADDI = 3'd5;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_1 = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_1  = ADDR_W'(1);

  state_t state, state_next;
  logic   handshake;
  logic   op_ok;

  function automatic logic [31:0] encode(
    input logic [2:0]  op,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_shamt,
    input logic [5:0]  f_funct,
    input logic [15:0] f_imm,
    input logic [25:0] f_target
  );
    logic [31:0] word;
    word = '0;
    case (op)
      OP_R:    word = {6'b000000, f_rs, f_rt, f_rd, f_shamt, f_funct};
      OP_LW:   word = {6'b100011, f_rs, f_rt, f_imm};
      OP_SW:   word = {6'b101011, f_rs, f_rt, f_imm};
      OP_BEQ:  word = {6'b000100, f_rs, f_rt, f_imm};
      OP_J:    word = {6'b000010, f_target};
      OP_ADDI: word = {6'b001000, f_rs, f_rt, f_imm};
      default: word = '0;
    endcase
    return word;
  endfunction

  // Status outputs are pure decodes of the state register, so in_ready never
  // depends on in_valid and nothing from the request reaches imem_* unregistered.
  assign req.in_ready = (state == IDLE);
  assign imem_we      = (state == WRITE);
  assign done         = (state == FULL);

  assign handshake = req.in_valid & req.in_ready;
  assign op_ok     = (req.op_sel <= OP_ADDI);

  // NOTE: every combinational output gets a default before the case so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake && op_ok) state_next = WRITE;
      WRITE:   state_next = ((count + COUNT_1) == DEPTH_C) ? FULL : IDLE;
      FULL:    state_next = FULL;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      imem_addr  <= BASE_C;
      imem_wdata <= '0;
      err        <= 1'b0;
      count      <= '0;
    end else begin
      state <= state_next;
      err   <= handshake && !op_ok;
      if (handshake && op_ok) begin
        imem_wdata <= encode(req.op_sel, req.rs, req.rt, req.rd, req.shamt,
                             req.funct, req.imm, req.target);
      end
      // Address wraps naturally at 2**ADDR_W when BASE_ADDR + DEPTH overruns it.
      if (state == WRITE) begin
        imem_addr <= imem_addr + ADDR_1;
        count     <= count + COUNT_1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding table, held-valid back-to-back,
// invalid op_sel, reset during WRITE, and address wrap / FULL with a small DEPTH.
module tb_instr_encoder_loader;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] word;
    logic        bad;
  } vec_t;

  localparam int NVEC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_encoder_loader_if ia ();
  instr_encoder_loader_if ib ();

  logic        a_we, a_err, a_done;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_count;
  logic        b_we, b_err, b_done;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;
  logic [8:0]  b_count;

  instr_encoder_loader dut_a (
    .clk(clk), .reset(reset), .req(ia.slave),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .err(a_err), .done(a_done), .count(a_count)
  );

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(254)) dut_b (
    .clk(clk), .reset(reset), .req(ib.slave),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .err(b_err), .done(b_done), .count(b_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_a(input vec_t v);
    ia.in_valid = 1'b1;
    ia.op_sel   = v.op;
    ia.rs       = v.rs;
    ia.rt       = v.rt;
    ia.rd       = v.rd;
    ia.shamt    = v.shamt;
    ia.funct    = v.funct;
    ia.imm      = v.imm;
    ia.target   = v.target;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs [NVEC];
  logic [31:0] b_words [4];
  logic [7:0]  b_addrs [4];
  logic [7:0]  exp_addr;
  int          exp_count;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          op    rs     rt     rd     shamt  funct  imm        target        word          bad
    vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 26'h0000000, 32'h00221820, 1'b0};
    vecs[1] = '{3'd1, 5'd16, 5'd8,  5'd0,  5'd0,  6'h00, 16'h0004, 26'h0000000, 32'h8E080004, 1'b0};
    vecs[2] = '{3'd2, 5'd29, 5'd31, 5'd0,  5'd0,  6'h00, 16'h0000, 26'h0000000, 32'hAFBF0000, 1'b0};
    vecs[3] = '{3'd3, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0000000, 32'h1022FFFF, 1'b0};
    vecs[4] = '{3'd4, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0000010, 32'h08000010, 1'b0};
    vecs[5] = '{3'd5, 5'd0,  5'd5,  5'd0,  5'd0,  6'h00, 16'h0007, 26'h0000000, 32'h20050007, 1'b0};
    vecs[6] = '{3'd6, 5'd1,  5'd1,  5'd1,  5'd1,  6'h01, 16'h1234, 26'h0000001, 32'h00000000, 1'b1};
    vecs[7] = '{3'd0, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hBEEF, 26'h2AAAAAA, 32'h03FFFFFF, 1'b0};
    vecs[8] = '{3'd7, 5'd2,  5'd3,  5'd4,  5'd5,  6'h06, 16'h0707, 26'h0000008, 32'h00000000, 1'b1};
    vecs[9] = '{3'd4, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h0BFFFFFF, 1'b0};

    b_words[0] = 32'h20010001; b_addrs[0] = 8'd254;
    b_words[1] = 32'h20020002; b_addrs[1] = 8'd255;
    b_words[2] = 32'h20030003; b_addrs[2] = 8'd0;
    b_words[3] = 32'h20040004; b_addrs[3] = 8'd1;

    reset = 1'b1;
    drive_a(vecs[0]);
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
    ib.op_sel = 3'd0; ib.rs = '0; ib.rt = '0; ib.rd = '0; ib.shamt = '0;
    ib.funct = '0; ib.imm = '0; ib.target = '0;

    // ---- reset state ----
    tick();
    tick();
    check("rst_we",    32'(a_we),    0);
    check("rst_err",   32'(a_err),   0);
    check("rst_done",  32'(a_done),  0);
    check("rst_count", 32'(a_count), 0);
    check("rst_addr",  32'(a_addr),  0);
    check("rst_wdata", a_wdata,      0);
    check("rst_b_addr", 32'(b_addr), 254);
    reset = 1'b0;
    tick();
    check("rst_ready", 32'(ia.in_ready), 1);
    exp_addr  = 8'd0;
    exp_count = 0;

    // ---- table-driven encodings, including invalid op_sel ----
    for (int i = 0; i < NVEC; i++) begin
      drive_a(vecs[i]);
      tick();
      ia.in_valid = 1'b0;
      if (vecs[i].bad) begin
        check($sformatf("v%0d_err_pulse", i), 32'(a_err), 1);
        check($sformatf("v%0d_err_no_we", i), 32'(a_we), 0);
        check($sformatf("v%0d_err_ready", i), 32'(ia.in_ready), 1);
        tick();
        check($sformatf("v%0d_err_clear", i), 32'(a_err), 0);
        check($sformatf("v%0d_err_we", i),    32'(a_we), 0);
        check($sformatf("v%0d_err_addr", i),  32'(a_addr), 32'(exp_addr));
        check($sformatf("v%0d_err_count", i), 32'(a_count), 32'(exp_count));
      end else begin
        check($sformatf("v%0d_we", i),        32'(a_we), 1);
        check($sformatf("v%0d_wdata", i),     a_wdata, vecs[i].word);
        check($sformatf("v%0d_addr", i),      32'(a_addr), 32'(exp_addr));
        check($sformatf("v%0d_ready_low", i), 32'(ia.in_ready), 0);
        tick();
        exp_addr  = exp_addr + 8'd1;
        exp_count = exp_count + 1;
        check($sformatf("v%0d_we_drop", i),   32'(a_we), 0);
        check($sformatf("v%0d_count", i),     32'(a_count), 32'(exp_count));
        check($sformatf("v%0d_addr_inc", i),  32'(a_addr), 32'(exp_addr));
      end
    end

    // ---- held in_valid: lw then sw back-to-back ----
    drive_a(vecs[1]);
    tick();
    check("b2b_lw_we",    32'(a_we), 1);
    check("b2b_lw_wdata", a_wdata, 32'h8E080004);
    check("b2b_lw_addr",  32'(a_addr), 32'(exp_addr));
    check("b2b_lw_ready", 32'(ia.in_ready), 0);
    drive_a(vecs[2]);
    tick();
    exp_addr  = exp_addr + 8'd1;
    exp_count = exp_count + 1;
    check("b2b_gap_we",    32'(a_we), 0);
    check("b2b_gap_ready", 32'(ia.in_ready), 1);
    tick();
    ia.in_valid = 1'b0;
    check("b2b_sw_we",    32'(a_we), 1);
    check("b2b_sw_wdata", a_wdata, 32'hAFBF0000);
    check("b2b_sw_addr",  32'(a_addr), 32'(exp_addr));
    check("b2b_sw_ready", 32'(ia.in_ready), 0);
    tick();
    exp_addr  = exp_addr + 8'd1;
    exp_count = exp_count + 1;
    check("b2b_count", 32'(a_count), 32'(exp_count));

    // ---- reset asserted during a WRITE cycle ----
    drive_a(vecs[3]);
    tick();
    ia.in_valid = 1'b0;
    check("rw_we", 32'(a_we), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_no_we", 32'(a_we),    0);
    check("rw_count", 32'(a_count), 0);
    check("rw_addr",  32'(a_addr),  0);
    tick();
    check("rw_ready", 32'(ia.in_ready), 1);
    check("rw_idle_we", 32'(a_we), 0);

    // ---- DEPTH=4 at BASE_ADDR=254: wrap, FULL, ignored fifth request ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      ib.in_valid = 1'b1;
      ib.op_sel   = 3'd5;
      ib.rs       = 5'd0;
      ib.rt       = 5'(k + 1);
      ib.imm      = 16'(k + 1);
      tick();
      ib.in_valid = 1'b0;
      check($sformatf("wrap%0d_we", k),    32'(b_we), 1);
      check($sformatf("wrap%0d_addr", k),  32'(b_addr), 32'(b_addrs[k]));
      check($sformatf("wrap%0d_wdata", k), b_wdata, b_words[k]);
      tick();
    end
    check("full_done",  32'(b_done),  1);
    check("full_ready", 32'(ib.in_ready), 0);
    check("full_count", 32'(b_count), 4);
    check("full_we",    32'(b_we),    0);
    ib.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("full_ign%0d_we", k),    32'(b_we), 0);
      check($sformatf("full_ign%0d_count", k), 32'(b_count), 4);
    end
    ib.in_valid = 1'b0;

    // ---- reset out of FULL ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("fr_count", 32'(b_count), 0);
    check("fr_addr",  32'(b_addr),  254);
    check("fr_done",  32'(b_done),  0);
    tick();
    check("fr_ready", 32'(ib.in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart to the main control decoder.
- Accepts symbolic instruction requests (operation class plus fields) over a valid/ready handshake.
- Assembles each request into a 32-bit MIPS word using the opcodes the decoder recognises: R-type, lw, sw, beq, j, addi.
- Writes assembled words sequentially into the instruction memory write port. Used by benches and boot logic to preload programs for the single-cycle CPU.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address.
- DEPTH, 256, number of words that may be written before the block reports full; legal range 1..2**ADDR_W.
- BASE_ADDR, 0, first word address written after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request this cycle.
- op_sel  input  3  operation class: 0=R, 1=lw, 2=sw, 3=beq, 4=j, 5=addi; 6 and 7 are invalid.
- rs  input  5  source register field.
- rt  input  5  target register field.
- rd  input  5  destination register field (R-type only).
- shamt  input  5  shift amount (R-type only).
- funct  input  6  function code (R-type only).
- imm  input  16  immediate / offset (lw, sw, beq, addi).
- target  input  26  jump target (j only).
- imem_we  output  1  instruction-memory write enable; one-cycle pulse per word.
- imem_addr  output  ADDR_W  write word address.
- imem_wdata  output  32  assembled instruction word.
- err  output  1  one-cycle pulse: the request had an invalid op_sel.
- done  output  1  DEPTH words written; level signal.
- count  output  ADDR_W+1  number of words written since reset.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Ports are named clk and reset.
- Reset values:
  - FSM state = IDLE.
  - in_ready = 1 in the cycle after reset deasserts.
  - imem_we = 0, err = 0, done = 0, count = 0.
  - imem_addr = BASE_ADDR, imem_wdata = 0.
- FSM states: IDLE, WRITE, FULL.
- IDLE:
  - in_ready = 1.
  - A handshake occurs when in_valid & in_ready.
  - On handshake, fields are captured and the word is assembled into the imem_wdata register.
  - Valid op_sel: go to WRITE.
  - Invalid op_sel (6 or 7): err = 1 for the next cycle only. Nothing is written, address and count are unchanged, state stays IDLE.
- WRITE:
  - Lasts exactly one cycle. imem_we = 1 with the registered imem_addr and imem_wdata; in_ready = 0.
  - At the end of the cycle: imem_addr += 1 and count += 1.
  - If the new count equals DEPTH, go to FULL; otherwise go to IDLE.
- Latency and throughput: a handshake in cycle N produces imem_we in cycle N+1. Maximum throughput is one word per 2 cycles.
- FULL:
  - in_ready = 0, done = 1, imem_we = 0.
  - Remains in FULL until reset; in_valid is ignored.
- Encoding, bits [31:26] opcode:
  - R: {6'b000000, rs, rt, rd, shamt, funct}
  - lw: {6'b100011, rs, rt, imm}
  - sw: {6'b101011, rs, rt, imm}
  - beq: {6'b000100, rs, rt, imm}
  - j: {6'b000010, target}
  - addi: {6'b001000, rs, rt, imm}
  - Fields not used by an op_sel are ignored. No sign extension is performed; imm is passed through verbatim.
- Address arithmetic: imem_addr wraps modulo 2**ADDR_W. This can only occur when BASE_ADDR + DEPTH > 2**ADDR_W, and is legal.
- Handshake rules:
  - Request inputs must hold stable only in the handshake cycle.
  - in_ready does not depend combinationally on in_valid.
  - in_valid while in_ready = 0 is not accepted; the requester must hold it.
- Reset mid-operation: reset during WRITE takes priority. imem_we = 0 in the following cycle and there is no count increment.
- Reset during FULL returns to IDLE with count = 0 and imem_addr = BASE_ADDR.
- Outputs are registered; no combinational path exists from inputs to imem_*.

Test Plan:
- Reset then R request (rs=1, rt=2, rd=3, shamt=0, funct=0x20) -> next cycle imem_we=1, imem_addr=0, imem_wdata=0x00221820; count=1.
- lw (rs=16, rt=8, imm=4), then sw (rs=29, rt=31, imm=0) back-to-back with in_valid held high -> writes 0x8E080004 at addr 0 and 0xAFBF0000 at addr 1; in_ready low in each WRITE cycle.
- beq (rs=1, rt=2, imm=0xFFFF), j (target=0x10), addi (rs=0, rt=5, imm=7) -> 0x1022FFFF, 0x08000010, 0x20050007 at addrs 0, 1, 2.
- op_sel=6 -> err pulse for exactly 1 cycle; imem_we stays 0; count and imem_addr unchanged; next valid request is written at the unchanged address.
- DEPTH=4, BASE_ADDR=254, ADDR_W=8, 4 valid requests -> addresses 254, 255, 0, 1; then done=1, in_ready=0, count=4; a fifth request is not accepted.
- Reset asserted in the WRITE cycle of a request -> no write on the next cycle; count=0, imem_addr=BASE_ADDR, in_ready=1 one cycle after reset drops.
